// File: rtl/modexp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation controller: operand width
// default and FSM state encoding.
package modexp_ctrl_pkg;

    localparam int MPWID_DEFAULT = 32;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SQR_REQ  = 3'd1;
    localparam logic [2:0] ST_SQR_WAIT = 3'd2;
    localparam logic [2:0] ST_MUL_REQ  = 3'd3;
    localparam logic [2:0] ST_MUL_WAIT = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    function automatic logic is_req_state(input logic [2:0] st);
        return (st == ST_SQR_REQ) || (st == ST_MUL_REQ);
    endfunction

    function automatic logic is_mul_state(input logic [2:0] st);
        return (st == ST_MUL_REQ) || (st == ST_MUL_WAIT);
    endfunction

endpackage

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer driving an external modular
// multiplier; holds operands and the accumulator, nothing arithmetic inside.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start; result held
// SQR_REQ   | waiting for mm_ready, then strobe breg*breg
// SQR_WAIT  | waiting for squaring product
// MUL_REQ   | waiting for mm_ready, then strobe acc*breg
// MUL_WAIT  | waiting for multiply product
// DONE      | publish acc to result, pulse done
module modexp_ctrl
    import modexp_ctrl_pkg::*;
#(
    parameter int MPWID = MPWID_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [MPWID-1:0] base,
    input  logic [MPWID-1:0] exponent,
    input  logic [MPWID-1:0] modulus,
    output logic [MPWID-1:0] result,
    output logic             busy,
    output logic             done,
    output logic [MPWID-1:0] mm_mpand,
    output logic [MPWID-1:0] mm_mplier,
    output logic [MPWID-1:0] mm_modulus,
    output logic             mm_ds,
    input  logic             mm_ready,
    input  logic [MPWID-1:0] mm_product
);

    localparam logic [MPWID-1:0] ONE = {{(MPWID-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [MPWID-1:0] acc_q, acc_d;
    logic [MPWID-1:0] breg_q, breg_d;
    logic [MPWID-1:0] ereg_q, ereg_d;
    logic [MPWID-1:0] mreg_q, mreg_d;
    logic [MPWID-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wait_first_q, wait_first_d;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        breg_d       = breg_q;
        ereg_d       = ereg_q;
        mreg_d       = mreg_q;
        result_d     = result_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        wait_first_d = wait_first_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    breg_d = base;
                    ereg_d = exponent;
                    mreg_d = modulus;
                    acc_d  = ONE;
                    busy_d = 1'b1;
                    if (exponent[0])
                        state_d = ST_MUL_REQ;
                    else if (exponent > ONE)
                        state_d = ST_SQR_REQ;
                    else
                        state_d = ST_DONE;
                end
            end
            ST_SQR_REQ: begin
                if (mm_ready) begin
                    state_d      = ST_SQR_WAIT;
                    wait_first_d = 1'b1;
                end
            end
            ST_MUL_REQ: begin
                if (mm_ready) begin
                    state_d      = ST_MUL_WAIT;
                    wait_first_d = 1'b1;
                end
            end
            // The multiplier still shows the previous ready for one cycle after mm_ds.
            ST_SQR_WAIT: begin
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (mm_ready) begin
                    breg_d  = mm_product;
                    ereg_d  = ereg_q >> 1;
                    state_d = ereg_q[1] ? ST_MUL_REQ : ST_SQR_REQ;
                end
            end
            ST_MUL_WAIT: begin
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (mm_ready) begin
                    acc_d   = mm_product;
                    state_d = ((ereg_q >> 1) != '0) ? ST_SQR_REQ : ST_DONE;
                end
            end
            ST_DONE: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            breg_q       <= '0;
            ereg_q       <= '0;
            mreg_q       <= '0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            breg_q       <= breg_d;
            ereg_q       <= ereg_d;
            mreg_q       <= mreg_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wait_first_q <= wait_first_d;
        end
    end

    assign result     = result_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign mm_ds      = mm_ready && is_req_state(state_q);
    assign mm_mpand   = is_mul_state(state_q) ? acc_q : breg_q;
    assign mm_mplier  = breg_q;
    assign mm_modulus = mreg_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl with a random-latency modular multiplier model and
// scoreboards for results and multiplier requests.
module tb_modexp_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] base, exponent, modulus;
    logic [31:0] result;
    logic        busy, done;
    logic [31:0] mm_mpand, mm_mplier, mm_modulus;
    logic        mm_ds;
    logic        mm_ready;
    logic [31:0] mm_product;

    modexp_ctrl #(.MPWID(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base       (base),
        .exponent   (exponent),
        .modulus    (modulus),
        .result     (result),
        .busy       (busy),
        .done       (done),
        .mm_mpand   (mm_mpand),
        .mm_mplier  (mm_mplier),
        .mm_modulus (mm_modulus),
        .mm_ds      (mm_ds),
        .mm_ready   (mm_ready),
        .mm_product (mm_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_mul;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_res_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int req_cnt  = 0;
    int mul_cnt  = 0;
    int sqr_cnt  = 0;

    function automatic logic [31:0] mulmod(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] m);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        return 32'(p % {32'b0, m});
    endfunction

    // Left-to-right reference, independent of the controller's bit order.
    function automatic logic [31:0] golden(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] m);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 31; i >= 0; i--) begin
            r = mulmod(r, r, m);
            if (e[i]) r = mulmod(r, b, m);
        end
        return r;
    endfunction

    task automatic push_reqs(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        logic [31:0] acc, bb, ee;
        req_t r;
        acc = 32'd1; bb = b; ee = e;
        while (ee != 0) begin
            if (ee[0]) begin
                r.is_mul = 1'b1; r.a = acc; r.b = bb; r.m = m;
                exp_req_q.push_back(r);
                acc = mulmod(acc, bb, m);
            end
            if ((ee >> 1) != 0) begin
                r.is_mul = 1'b0; r.a = bb; r.b = bb; r.m = m;
                exp_req_q.push_back(r);
                bb = mulmod(bb, bb, m);
            end
            ee = ee >> 1;
        end
    endtask

    // Multiplier model: ready drops one cycle after the strobe, returns after 5-40 cycles.
    int          ph_q;
    int          lat_q;
    logic [31:0] prod_q;
    always @(posedge clk) begin
        if (reset) begin
            mm_ready   <= 1'b1;
            mm_product <= '0;
            ph_q       <= 0;
            lat_q      <= 0;
        end else begin
            case (ph_q)
                0: if (mm_ds) begin
                    prod_q <= mulmod(mm_mpand, mm_mplier, mm_modulus);
                    lat_q  <= int'($urandom_range(40, 5));
                    ph_q   <= 1;
                end
                1: begin
                    mm_ready <= 1'b0;
                    ph_q     <= 2;
                end
                default: begin
                    if (lat_q <= 1) begin
                        mm_product <= prod_q;
                        mm_ready   <= 1'b1;
                        ph_q       <= 0;
                    end else begin
                        lat_q <= lat_q - 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (mm_ds) begin
                req_t r;
                req_cnt++;
                n_tests++;
                if (mm_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ds_while_not_ready: mm_ready=%0b required 1", mm_ready);
                end
                n_tests++;
                if (exp_req_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_request: mpand=%0d mplier=%0d, no request expected",
                             mm_mpand, mm_mplier);
                end else begin
                    r = exp_req_q.pop_front();
                    if (r.is_mul) mul_cnt++; else sqr_cnt++;
                    if (mm_mpand !== r.a || mm_mplier !== r.b || mm_modulus !== r.m) begin
                        n_fail++;
                        $display("FAIL request_operands: got %0d*%0d mod %0d required %0d*%0d mod %0d",
                                 mm_mpand, mm_mplier, mm_modulus, r.a, r.b, r.m);
                    end
                end
            end
            if (done) begin
                logic [31:0] er;
                done_cnt++;
                n_tests++;
                if (exp_res_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: result=%0d, no result expected", result);
                end else begin
                    er = exp_res_q.pop_front();
                    if (result !== er) begin
                        n_fail++;
                        $display("FAIL result: got %0d required %0d", result, er);
                    end
                end
            end
        end
    end

    task automatic wait_done(input int d0, input string name);
        for (int i = 0; i < 5000 && done_cnt == d0; i++) @(posedge clk);
        n_tests++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL %s_timeout: done count %0d required %0d", name, done_cnt, d0 + 1);
        end
    endtask

    task automatic run_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                          input logic [31:0] exp_result, input int exp_mul, input int exp_sqr,
                          input string name);
        int d0, m0, s0;
        exp_res_q.push_back(exp_result);
        push_reqs(b, e, m);
        d0 = done_cnt; m0 = mul_cnt; s0 = sqr_cnt;
        @(posedge clk); #1;
        base = b; exponent = e; modulus = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy: got %0b required 1", name, busy);
        end
        wait_done(d0, name);
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL %s_done_pulses: got %0d required 1", name, done_cnt - d0);
        end
        n_tests++;
        if (mul_cnt - m0 != exp_mul || sqr_cnt - s0 != exp_sqr) begin
            n_fail++;
            $display("FAIL %s_req_counts: got mul=%0d sqr=%0d required mul=%0d sqr=%0d",
                     name, mul_cnt - m0, sqr_cnt - s0, exp_mul, exp_sqr);
        end
        n_tests++;
        if (busy !== 1'b0 || result !== exp_result) begin
            n_fail++;
            $display("FAIL %s_held: got busy=%0b result=%0d required busy=0 result=%0d",
                     name, busy, result, exp_result);
        end
    endtask

    task automatic check_reset_state(input string name);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || mm_ds !== 1'b0 ||
            mm_mpand !== 32'd0 || mm_mplier !== 32'd0 || mm_modulus !== 32'd0) begin
            n_fail++;
            $display("FAIL %s: got busy=%0b done=%0b result=%0d ds=%0b ops=%0d/%0d/%0d required all 0",
                     name, busy, done, result, mm_ds, mm_mpand, mm_mplier, mm_modulus);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("idle_after_reset");
    endtask

    task automatic test_vectors();
        run_op(32'd4, 32'd13, 32'd497, 32'd445, 3, 3, "pow_4_13_497");
        run_op(32'd2, 32'd10, 32'd1000, 32'd24, 2, 3, "pow_2_10_1000");
        run_op(32'd7, 32'd1, 32'd11, 32'd7, 1, 0, "pow_7_1_11");
    endtask

    task automatic test_exp_zero();
        int d0, r0;
        exp_res_q.push_back(32'd1);
        d0 = done_cnt; r0 = req_cnt;
        @(posedge clk); #1;
        base = 32'd5; exponent = 32'd0; modulus = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL exp0_cycle1: got done=%0b busy=%0b required done=0 busy=1", done, busy);
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== 32'd1) begin
            n_fail++;
            $display("FAIL exp0_cycle2: got done=%0b busy=%0b result=%0d required done=1 busy=0 result=1",
                     done, busy, result);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (req_cnt != r0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL exp0_no_requests: got reqs=%0d dones=%0d required reqs=0 dones=1",
                     req_cnt - r0, done_cnt - d0);
        end
    endtask

    task automatic test_start_while_busy();
        int d0;
        exp_res_q.push_back(32'd445);
        push_reqs(32'd4, 32'd13, 32'd497);
        d0 = done_cnt;
        @(posedge clk); #1;
        base = 32'd4; exponent = 32'd13; modulus = 32'd497; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        base = 32'd3; exponent = 32'd255; modulus = 32'd1001; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d0, "busy_ignore");
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (done_cnt - d0 != 1 || result !== 32'd445 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore: got dones=%0d result=%0d busy=%0b required dones=1 result=445 busy=0",
                     done_cnt - d0, result, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int d0, r0;
        exp_res_q.push_back(32'd445);
        push_reqs(32'd4, 32'd13, 32'd497);
        d0 = done_cnt; r0 = req_cnt;
        @(posedge clk); #1;
        base = 32'd4; exponent = 32'd13; modulus = 32'd497; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Second request is the first squaring; one edge later the DUT waits on it.
        for (int i = 0; i < 2000 && req_cnt < r0 + 2; i++) @(posedge clk);
        n_tests++;
        if (req_cnt < r0 + 2) begin
            n_fail++;
            $display("FAIL midreset_reach_sqr: got reqs=%0d required 2", req_cnt - r0);
        end
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("midreset_state");
        exp_res_q.delete();
        exp_req_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got dones=%0d busy=%0b required dones=0 busy=0",
                     done_cnt - d0, busy);
        end
        run_op(32'd4, 32'd13, 32'd497, 32'd445, 3, 3, "after_midreset");
    endtask

    task automatic test_random();
        logic [31:0] b, e, m;
        int bl;
        for (int k = 0; k < 6; k++) begin
            m = (k % 2 == 0) ? 32'($urandom_range(1000, 2)) : ($urandom | 32'h8000_0000);
            b = $urandom % m;
            e = 32'($urandom_range(65535, 0));
            bl = 0;
            for (int i = 0; i < 32; i++) if (e[i]) bl = i + 1;
            run_op(b, e, m, golden(b, e, m), $countones(e), (bl > 0) ? bl - 1 : 0, "random");
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        base = '0; exponent = '0; modulus = 32'd2;
        test_reset();
        test_vectors();
        test_exp_zero();
        test_start_while_busy();
        test_reset_mid_op();
        test_random();
        n_tests++;
        if (exp_res_q.size() != 0 || exp_req_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expectations: results=%0d requests=%0d required 0/0",
                     exp_res_q.size(), exp_req_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
